// File: rtl/relu_maxpool_if.sv
// Shared word-addressed memory handshake seen by the pooling stage.
// The stage drives the request side; memory returns data and a one-cycle done pulse.
interface relu_maxpool_if;
   logic        mem_opdone;
   logic [31:0] data_i;
   logic [31:0] data_o;
   logic [31:0] addr_o;
   logic [1:0]  mem_operation;

   modport master (
      input  mem_opdone,
      input  data_i,
      output data_o,
      output addr_o,
      output mem_operation
   );

   modport slave (
      output mem_opdone,
      output data_i,
      input  data_o,
      input  addr_o,
      input  mem_operation
   );
endinterface

// File: rtl/relu_maxpool.sv
// ReLU + 2x2/stride-2 max pooling over the convolution result held in shared memory.
// Pooled words are written directly after the result region.
module relu_maxpool #(
   parameter bit RELU_EN = 1'b1
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           enable,
   output logic           done,
   relu_maxpool_if.master mem
);
   typedef enum logic [2:0] {
      S_DONE, S_START, S_FETCH, S_ROW, S_COL, S_READ, S_WRITE
   } state_t;

   localparam logic [1:0] OP_NONE  = 2'b00;
   localparam logic [1:0] OP_READ  = 2'b01;
   localparam logic [1:0] OP_WRITE = 2'b11;

   state_t      state_q, state_d;
   logic        last_enable_q, last_enable_d;
   logic        done_q, done_d;
   logic [1:0]  op_q, op_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] data_q, data_d;
   logic [31:0] w_q, w_d, h_q, h_d, wf_q, wf_d, hf_q, hf_d;
   logic [31:0] ib_q, ib_d, ob_q, ob_d, rw_q, rw_d, pw_q, pw_d, ph_q, ph_d;
   logic [31:0] r_q, r_d, c_q, c_d, max_q, max_d;
   logic [2:0]  idx_q, idx_d;

   logic [31:0] rh_calc, rw_calc, ib_calc, read_addr, write_addr;
   logic        accept;

   assign rh_calc    = h_q - hf_q + 32'd1;
   assign rw_calc    = w_q - wf_q + 32'd1;
   assign ib_calc    = 32'd4 + 32'd2 * h_q * w_q + hf_q * wf_q;
   // idx[1] selects the lower window row, idx[0] the right-hand column
   assign read_addr  = ib_q + ((r_q << 1) + {31'd0, idx_q[1]}) * rw_q
                       + (c_q << 1) + {31'd0, idx_q[0]};
   assign write_addr = ob_q + r_q * pw_q + c_q;
   assign accept     = (op_q != OP_NONE) && mem.mem_opdone;

   assign done              = done_q;
   assign mem.addr_o        = addr_q;
   assign mem.data_o        = data_q;
   assign mem.mem_operation = op_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= S_DONE;
         last_enable_q <= 1'b0;
         done_q        <= 1'b0;
         op_q          <= OP_NONE;
         addr_q        <= '0;
         data_q        <= '0;
         w_q <= '0; h_q <= '0; wf_q <= '0; hf_q <= '0;
         ib_q <= '0; ob_q <= '0; rw_q <= '0; pw_q <= '0; ph_q <= '0;
         r_q <= '0; c_q <= '0; max_q <= '0; idx_q <= '0;
      end else begin
         state_q       <= state_d;
         last_enable_q <= last_enable_d;
         done_q        <= done_d;
         op_q          <= op_d;
         addr_q        <= addr_d;
         data_q        <= data_d;
         w_q <= w_d; h_q <= h_d; wf_q <= wf_d; hf_q <= hf_d;
         ib_q <= ib_d; ob_q <= ob_d; rw_q <= rw_d; pw_q <= pw_d; ph_q <= ph_d;
         r_q <= r_d; c_q <= c_d; max_q <= max_d; idx_q <= idx_d;
      end
   end

   // A request is raised only from an idle bus, so every accept is followed by one 00 cycle.
   always_comb begin
      state_d       = state_q;
      last_enable_d = last_enable_q;
      done_d        = done_q;
      op_d          = op_q;
      addr_d        = addr_q;
      data_d        = data_q;
      w_d = w_q; h_d = h_q; wf_d = wf_q; hf_d = hf_q;
      ib_d = ib_q; ob_d = ob_q; rw_d = rw_q; pw_d = pw_q; ph_d = ph_q;
      r_d = r_q; c_d = c_q; max_d = max_q; idx_d = idx_q;

      case (state_q)
         S_DONE: begin
            done_d        = 1'b1;
            last_enable_d = enable;
            if (enable && !last_enable_q) state_d = S_START;
         end
         S_START: begin
            r_d     = '0;
            c_d     = '0;
            idx_d   = '0;
            max_d   = '0;
            done_d  = 1'b0;
            state_d = S_FETCH;
         end
         S_FETCH: begin
            if (idx_q == 3'd4) begin
               ib_d  = ib_calc;
               ob_d  = ib_calc + rh_calc * rw_calc;
               rw_d  = rw_calc;
               pw_d  = rw_calc >> 1;
               ph_d  = rh_calc >> 1;
               idx_d = '0;
               if ((h_q < hf_q) || (w_q < wf_q) || ((rh_calc >> 1) == 32'd0)
                   || ((rw_calc >> 1) == 32'd0))
                  state_d = S_DONE;
               else
                  state_d = S_ROW;
            end else if (op_q == OP_NONE) begin
               op_d   = OP_READ;
               addr_d = {29'd0, idx_q};
            end else if (accept) begin
               op_d  = OP_NONE;
               idx_d = idx_q + 3'd1;
               case (idx_q[1:0])
                  2'd0:    w_d  = mem.data_i;
                  2'd1:    h_d  = mem.data_i;
                  2'd2:    wf_d = mem.data_i;
                  default: hf_d = mem.data_i;
               endcase
            end
         end
         S_ROW: begin
            if (r_q < ph_q) begin
               c_d     = '0;
               state_d = S_COL;
            end else begin
               state_d = S_DONE;
            end
         end
         S_COL: begin
            if (c_q < pw_q) begin
               max_d   = '0;
               idx_d   = '0;
               state_d = S_READ;
            end else begin
               r_d     = r_q + 32'd1;
               state_d = S_ROW;
            end
         end
         S_READ: begin
            if (op_q == OP_NONE) begin
               op_d   = OP_READ;
               addr_d = read_addr;
            end else if (accept) begin
               op_d = OP_NONE;
               if ((!RELU_EN && idx_q == 3'd0) || ($signed(mem.data_i) > $signed(max_q)))
                  max_d = mem.data_i;
               if (idx_q == 3'd3) begin
                  idx_d   = '0;
                  state_d = S_WRITE;
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end
         end
         S_WRITE: begin
            if (op_q == OP_NONE) begin
               op_d   = OP_WRITE;
               addr_d = write_addr;
               data_d = max_q;
            end else if (accept) begin
               op_d    = OP_NONE;
               c_d     = c_q + 32'd1;
               state_d = S_COL;
            end
         end
         default: state_d = S_DONE;
      endcase
   end
endmodule

// File: tb/tb_relu_maxpool.sv
// Directed bench for relu_maxpool: a behavioural memory answers the handshake with
// programmable latency and logs every read and write for the scenario tasks to inspect.
module tb_relu_maxpool;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic en1 = 1'b0;
   logic en0 = 1'b0;
   logic done1, done0;
   logic sel = 1'b1;

   logic        opdone_r;
   logic [31:0] rdata_r;
   logic [31:0] mem [0:255];

   logic [31:0] rd_addrs [$];
   logic [31:0] wr_addrs [$];
   logic [31:0] wr_data  [$];
   int fixed_lat = 1;
   bit rand_lat = 1'b0;
   int stab_err = 0;
   int gap_err = 0;
   int checks = 0;
   int errors = 0;

   relu_maxpool_if m1 ();
   relu_maxpool_if m0 ();

   relu_maxpool #(.RELU_EN(1'b1)) dut1 (
      .clk(clk), .reset(reset), .enable(en1), .done(done1), .mem(m1.master)
   );
   relu_maxpool #(.RELU_EN(1'b0)) dut0 (
      .clk(clk), .reset(reset), .enable(en0), .done(done0), .mem(m0.master)
   );

   always #5 clk = ~clk;

   assign m1.mem_opdone = opdone_r & sel;
   assign m0.mem_opdone = opdone_r & ~sel;
   assign m1.data_i     = rdata_r;
   assign m0.data_i     = rdata_r;

   logic [1:0]  bus_op;
   logic [31:0] bus_addr, bus_wdata;
   logic        done_s;
   assign bus_op    = sel ? m1.mem_operation : m0.mem_operation;
   assign bus_addr  = sel ? m1.addr_o : m0.addr_o;
   assign bus_wdata = sel ? m1.data_o : m0.data_o;
   assign done_s    = sel ? done1 : done0;

   // Memory responder: holds each request for its latency, checking stability and the idle gap.
   initial begin : responder
      logic [31:0] a, d;
      logic [1:0]  op;
      int          lat;
      bit          aborted;
      opdone_r = 1'b0;
      rdata_r  = '0;
      forever begin
         @(posedge clk); #1;
         if (!reset && bus_op != 2'b00) begin
            a = bus_addr; d = bus_wdata; op = bus_op; aborted = 1'b0;
            lat = rand_lat ? int'($urandom_range(1, 7)) : fixed_lat;
            for (int k = 1; k < lat && !aborted; k++) begin
               @(posedge clk); #1;
               if (reset) aborted = 1'b1;
               else if (bus_addr !== a || bus_op !== op || (op == 2'b11 && bus_wdata !== d))
                  stab_err++;
            end
            if (!aborted) begin
               if (op == 2'b11) begin
                  mem[a[7:0]] = d;
                  wr_addrs.push_back(a);
                  wr_data.push_back(d);
               end else begin
                  rdata_r = mem[a[7:0]];
                  rd_addrs.push_back(a);
               end
               opdone_r = 1'b1;
               @(posedge clk); #1;
               opdone_r = 1'b0;
               if (!reset && bus_op !== 2'b00) gap_err++;
            end
         end
      end
   end

   task automatic load_mem(input int unsigned w, h, wf, hf, input bit neg);
      int unsigned ib, n;
      logic [31:0] v;
      for (int i = 0; i < 256; i++) mem[i] = 32'd0;
      mem[0] = w; mem[1] = h; mem[2] = wf; mem[3] = hf;
      ib = 4 + 2 * h * w + hf * wf;
      n = (h >= hf && w >= wf) ? (h - hf + 1) * (w - wf + 1) : 0;
      for (int unsigned i = 0; i < n; i++) begin
         v = i + 1;
         if (neg) v = -v;
         mem[ib + i] = v;
      end
   endtask

   task automatic wait_run();
      int n;
      n = 0;
      while (done_s !== 1'b0 && n < 30) begin @(posedge clk); #1; n++; end
      n = 0;
      while (done_s !== 1'b1 && n < 5000) begin @(posedge clk); #1; n++; end
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic run_job(input bit which, input int lat, input bit rnd);
      sel = which; fixed_lat = lat; rand_lat = rnd;
      rd_addrs.delete(); wr_addrs.delete(); wr_data.delete();
      stab_err = 0; gap_err = 0;
      if (which) en1 = 1'b1; else en0 = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      en1 = 1'b0; en0 = 1'b0;
      wait_run();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (m1.mem_operation !== 2'b00 || m0.mem_operation !== 2'b00) begin
         errors++; $display("[TB] FAIL reset_op: got %b/%b expected 00", m1.mem_operation, m0.mem_operation);
      end
      checks++;
      if (m1.addr_o !== 32'd0 || m1.data_o !== 32'd0) begin
         errors++; $display("[TB] FAIL reset_bus: addr %h data %h expected 0", m1.addr_o, m1.data_o);
      end
      checks++;
      if (done1 !== 1'b0 || done0 !== 1'b0) begin
         errors++; $display("[TB] FAIL reset_done: got %b/%b expected 0", done1, done0);
      end
      reset = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (done1 !== 1'b1 || done0 !== 1'b1) begin
         errors++; $display("[TB] FAIL done_rise: got %b/%b expected 1", done1, done0);
      end
   endtask

   task automatic test_basic();
      int unsigned exp_rd [16] = '{58, 59, 62, 63, 60, 61, 64, 65, 66, 67, 70, 71, 68, 69, 72, 73};
      int unsigned exp_wa [4]  = '{74, 75, 76, 77};
      logic [31:0] exp_wd [4]  = '{32'd6, 32'd8, 32'd14, 32'd16};
      load_mem(5, 5, 2, 2, 1'b0);
      run_job(1'b1, 1, 1'b0);
      checks++;
      if (rd_addrs.size() != 20) begin
         errors++; $display("[TB] FAIL basic_rd_count: got %0d expected 20", rd_addrs.size());
      end
      for (int i = 0; i < 20 && i < rd_addrs.size(); i++) begin
         checks++;
         if (rd_addrs[i] !== ((i < 4) ? 32'(i) : 32'(exp_rd[i - 4]))) begin
            errors++; $display("[TB] FAIL basic_rd_addr[%0d]: got %0d expected %0d", i, rd_addrs[i],
                               (i < 4) ? i : int'(exp_rd[i - 4]));
         end
      end
      checks++;
      if (wr_addrs.size() != 4) begin
         errors++; $display("[TB] FAIL basic_wr_count: got %0d expected 4", wr_addrs.size());
      end
      for (int i = 0; i < 4 && i < wr_addrs.size(); i++) begin
         checks++;
         if (wr_addrs[i] !== exp_wa[i] || wr_data[i] !== exp_wd[i]) begin
            errors++; $display("[TB] FAIL basic_wr[%0d]: got %0d:%0d expected %0d:%0d", i,
                               wr_addrs[i], wr_data[i], exp_wa[i], exp_wd[i]);
         end
      end
      checks++;
      if (done1 !== 1'b1) begin
         errors++; $display("[TB] FAIL basic_done: got %b expected 1", done1);
      end
   endtask

   task automatic test_negative();
      logic [31:0] exp0 [4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFF7, 32'hFFFF_FFF5};
      load_mem(5, 5, 2, 2, 1'b1);
      run_job(1'b1, 1, 1'b0);
      checks++;
      if (wr_addrs.size() != 4) begin
         errors++; $display("[TB] FAIL relu_wr_count: got %0d expected 4", wr_addrs.size());
      end
      for (int i = 0; i < 4 && i < wr_addrs.size(); i++) begin
         checks++;
         if (wr_addrs[i] !== 32'(74 + i) || wr_data[i] !== 32'd0) begin
            errors++; $display("[TB] FAIL relu_wr[%0d]: got %0d:%h expected %0d:0", i,
                               wr_addrs[i], wr_data[i], 74 + i);
         end
      end
      load_mem(5, 5, 2, 2, 1'b1);
      run_job(1'b0, 1, 1'b0);
      checks++;
      if (wr_addrs.size() != 4) begin
         errors++; $display("[TB] FAIL smax_wr_count: got %0d expected 4", wr_addrs.size());
      end
      for (int i = 0; i < 4 && i < wr_addrs.size(); i++) begin
         checks++;
         if (wr_addrs[i] !== 32'(74 + i) || wr_data[i] !== exp0[i]) begin
            errors++; $display("[TB] FAIL smax_wr[%0d]: got %0d:%h expected %0d:%h", i,
                               wr_addrs[i], wr_data[i], 74 + i, exp0[i]);
         end
      end
      checks++;
      if (done0 !== 1'b1) begin
         errors++; $display("[TB] FAIL smax_done: got %b expected 1", done0);
      end
      sel = 1'b1;
   endtask

   task automatic test_odd();
      logic [31:0] exp_wd [4] = '{32'd7, 32'd9, 32'd17, 32'd19};
      int forbidden;
      load_mem(6, 6, 2, 2, 1'b0);
      run_job(1'b1, 1, 1'b0);
      forbidden = 0;
      foreach (rd_addrs[i])
         if ((rd_addrs[i] >= 100 && rd_addrs[i] <= 104) || rd_addrs[i] == 84 || rd_addrs[i] == 89
             || rd_addrs[i] == 94 || rd_addrs[i] == 99)
            forbidden++;
      checks++;
      if (rd_addrs.size() != 20 || forbidden != 0) begin
         errors++; $display("[TB] FAIL odd_reads: got %0d reads %0d forbidden expected 20 reads 0 forbidden",
                            rd_addrs.size(), forbidden);
      end
      checks++;
      if (wr_addrs.size() != 4) begin
         errors++; $display("[TB] FAIL odd_wr_count: got %0d expected 4", wr_addrs.size());
      end
      for (int i = 0; i < 4 && i < wr_addrs.size(); i++) begin
         checks++;
         if (wr_addrs[i] !== 32'(105 + i) || wr_data[i] !== exp_wd[i]) begin
            errors++; $display("[TB] FAIL odd_wr[%0d]: got %0d:%0d expected %0d:%0d", i,
                               wr_addrs[i], wr_data[i], 105 + i, exp_wd[i]);
         end
      end
   endtask

   task automatic test_degenerate();
      int unsigned cfg_hf [2] = '{3, 4};
      for (int t = 0; t < 2; t++) begin
         load_mem(3, 3, 3, cfg_hf[t], 1'b0);
         run_job(1'b1, 1, 1'b0);
         checks++;
         if (rd_addrs.size() != 4) begin
            errors++; $display("[TB] FAIL degen%0d_reads: got %0d expected 4", t, rd_addrs.size());
         end
         checks++;
         if (wr_addrs.size() != 0) begin
            errors++; $display("[TB] FAIL degen%0d_writes: got %0d expected 0", t, wr_addrs.size());
         end
         checks++;
         if (done1 !== 1'b1) begin
            errors++; $display("[TB] FAIL degen%0d_done: got %b expected 1", t, done1);
         end
      end
   endtask

   task automatic test_latency();
      logic [31:0] exp_wd [4] = '{32'd6, 32'd8, 32'd14, 32'd16};
      load_mem(5, 5, 2, 2, 1'b0);
      run_job(1'b1, 1, 1'b1);
      checks++;
      if (rd_addrs.size() != 20 || wr_addrs.size() != 4) begin
         errors++; $display("[TB] FAIL lat_counts: got %0d reads %0d writes expected 20 and 4",
                            rd_addrs.size(), wr_addrs.size());
      end
      for (int i = 0; i < 4 && i < wr_addrs.size(); i++) begin
         checks++;
         if (wr_addrs[i] !== 32'(74 + i) || wr_data[i] !== exp_wd[i]) begin
            errors++; $display("[TB] FAIL lat_wr[%0d]: got %0d:%0d expected %0d:%0d", i,
                               wr_addrs[i], wr_data[i], 74 + i, exp_wd[i]);
         end
      end
      checks++;
      if (stab_err != 0) begin
         errors++; $display("[TB] FAIL lat_stable: got %0d changes expected 0", stab_err);
      end
      checks++;
      if (gap_err != 0) begin
         errors++; $display("[TB] FAIL lat_gap: got %0d missing gaps expected 0", gap_err);
      end
   endtask

   task automatic test_reset_mid();
      int n;
      load_mem(5, 5, 2, 2, 1'b0);
      sel = 1'b1; fixed_lat = 4; rand_lat = 1'b0;
      rd_addrs.delete(); wr_addrs.delete(); wr_data.delete();
      en1 = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      en1 = 1'b0;
      n = 0;
      while (!(wr_addrs.size() == 1 && bus_op == 2'b11) && n < 3000) begin
         @(posedge clk); #1; n++;
      end
      checks++;
      if (!(wr_addrs.size() == 1 && bus_op == 2'b11)) begin
         errors++; $display("[TB] FAIL rst_reach: got %0d writes op %b expected 1 write op 11",
                            wr_addrs.size(), bus_op);
      end
      reset = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (m1.mem_operation !== 2'b00 || m1.addr_o !== 32'd0) begin
         errors++; $display("[TB] FAIL rst_abort: got op %b addr %0d expected 00 and 0",
                            m1.mem_operation, m1.addr_o);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      repeat (100) @(posedge clk);
      #1;
      checks++;
      if (wr_addrs.size() != 1 || done1 !== 1'b1) begin
         errors++; $display("[TB] FAIL rst_after: got %0d writes done %b expected 1 write done 1",
                            wr_addrs.size(), done1);
      end
      fixed_lat = 1;
   endtask

   task automatic test_enable_hold();
      load_mem(5, 5, 2, 2, 1'b0);
      sel = 1'b1; fixed_lat = 1; rand_lat = 1'b0;
      rd_addrs.delete(); wr_addrs.delete(); wr_data.delete();
      en1 = 1'b1;
      wait_run();
      repeat (50) @(posedge clk);
      #1;
      checks++;
      if (rd_addrs.size() != 20 || done1 !== 1'b1) begin
         errors++; $display("[TB] FAIL hold_norestart: got %0d reads done %b expected 20 reads done 1",
                            rd_addrs.size(), done1);
      end
      en1 = 1'b0;
      @(posedge clk); #1;
      rd_addrs.delete(); wr_addrs.delete(); wr_data.delete();
      en1 = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (done1 !== 1'b0) begin
         errors++; $display("[TB] FAIL hold_restart: got done %b expected 0", done1);
      end
      wait_run();
      checks++;
      if (wr_addrs.size() != 4 || done1 !== 1'b1) begin
         errors++; $display("[TB] FAIL hold_rerun: got %0d writes done %b expected 4 writes done 1",
                            wr_addrs.size(), done1);
      end
      en1 = 1'b0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_negative();
      test_odd();
      test_degenerate();
      test_latency();
      test_reset_mid();
      test_enable_hold();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
